branch_resolve: RTL
===================

# branch_resolve

ID-stage branch resolution and redirect controller for the 5-stage MIPS pipeline. It decodes conditional branches (beq, bne, blez, bgtz, bltz, bgez) and sizes the operand-hazard stall. It consumes the equality and sign flags of the ID-stage register comparator, computes the branch target, and issues a registered one-cycle PC redirect plus an IF/ID flush. It also keeps wrapping branch and taken counters for performance debug.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_rs, id_rt  in  5 each  source register fields
- id_imm  in  16  instruction[15:0]
- id_pc4  in  32  PC+4 of the ID instruction
- res_eq, gtz_sig, lez_sig, gez_sig, ltz_sig  in  1 each  comparator flags (RegS==RegT, RegS>0, <=0, >=0, <0, signed)
- ex_wr_en, ex_is_load  in  1 each  EX instruction writes a register / is a load
- ex_rd  in  5  EX destination
- mem_wr_en, mem_is_load  in  1 each  MEM equivalents
- mem_rd  in  5  MEM destination
- stall  out  1  hold PC and IF/ID; bubble into EX (combinational)
- pc_redirect  out  1  registered; load pc_target into PC this cycle
- pc_target  out  32  registered branch target
- flush_ifid  out  1  registered; equals pc_redirect
- br_cnt, taken_cnt  out  32 each  wrapping counts of resolved and taken branches

## Operation
- Branch decode (is_br):
  - 000100 beq: taken on res_eq.
  - 000101 bne: taken on !res_eq.
  - 000110 blez: taken on lez_sig.
  - 000111 bgtz: taken on gtz_sig.
  - 000001 REGIMM with id_rt=00000 bltz: taken on ltz_sig.
  - 000001 REGIMM with id_rt=00001 bgez: taken on gez_sig.
  - Any other REGIMM rt, and every other opcode: not a branch.
- Sources: rs always; rt only for beq/bne. Register $0 never matches.
- Hazard need N, taking the highest matching rule:
  - EX load writing a source: N=2.
  - EX non-load writer of a source: N=1.
  - MEM load writing a source: N=1.
  - Otherwise N=0.
- Target = id_pc4 + (sign-extended id_imm << 2), modulo 2^32.
- FSM states: IDLE, WAIT.
  - IDLE, is_br && id_valid && !ignore, N=0: resolve this cycle.
  - IDLE, same condition, N>0: stall=1, cnt<=N-1, go WAIT.
  - WAIT, cnt!=0: stall=1, cnt decrements.
  - WAIT, cnt==0: stall=0, resolve, go IDLE.
  - Hazard inputs are not re-sampled in WAIT.
- Resolve:
  - br_cnt+1.
  - If taken: taken_cnt+1, and next cycle pc_redirect=flush_ifid=1 with pc_target latched.
- ignore: the cycle pc_redirect is high, the ID instruction is the delay slot. A branch there is not evaluated, stalls nothing and is not counted.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, cnt=0.
  - stall=0, pc_redirect=0, flush_ifid=0.
  - pc_target=0, br_cnt=0, taken_cnt=0.
- Reset during WAIT aborts the branch with no redirect and no count.
- stall is combinational from the current-cycle inputs and state. Stall length is exactly N cycles.
- Resolve-to-redirect latency: 1 cycle. pc_redirect is high for exactly one cycle per taken branch.
- Not-taken branches produce no redirect or flush.
- Counters wrap 0xFFFFFFFF→0.

## Structure
- Shared package mips_pkg:
  - opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM.
  - RT_BLTZ, RT_BGEZ.
  - state enum br_state_t {IDLE, WAIT}.
- Sub-module branch_hazard: combinational computation of N from source and EX/MEM fields. The FSM, target adder and counters stay in the top.

## Test plan
- beq, res_eq=1, id_pc4=0x00400004, id_imm=0x0003, no hazard → no stall; next cycle pc_redirect=1, pc_target=0x00400010; br_cnt=1, taken_cnt=1.
- bne, res_eq=1 → no redirect; br_cnt+1, taken_cnt unchanged. Same with res_eq=0, id_imm=0xFFFF, id_pc4=0x1000 → pc_target=0x0FFC.
- bgtz on rs=5, EX load with ex_rd=5 → stall for exactly 2 cycles, then resolve; redirect 1 cycle later. EX ALU writer → 1 stall. ex_rd=0 → 0 stalls.
- REGIMM: rt=0 with ltz_sig=1 → taken. rt=1 with gez_sig=1 → taken. rt=2 → not a branch, no count.
- Branch in the delay slot (ID during the pc_redirect cycle) → ignored: no stall, no count.
- rst_n pulsed low in the second WAIT cycle → stall drops immediately; no redirect; counters 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the branch decode helper used by the ID-stage
// branch resolution logic.
package mips_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_ONE  = 2'd1;
    localparam logic [1:0] NEED_TWO  = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } br_state_t;

    typedef struct packed {
        logic is_br;
        logic use_rt;
        logic taken;
    } br_dec_t;

    function automatic br_dec_t decode_branch(
        input logic [5:0] opcode,
        input logic [4:0] rt,
        input logic       res_eq,
        input logic       gtz_sig,
        input logic       lez_sig,
        input logic       gez_sig,
        input logic       ltz_sig
    );
        br_dec_t d;
        d = '0;
        case (opcode)
            OP_BEQ: begin
                d.is_br  = 1'b1;
                d.use_rt = 1'b1;
                d.taken  = res_eq;
            end
            OP_BNE: begin
                d.is_br  = 1'b1;
                d.use_rt = 1'b1;
                d.taken  = !res_eq;
            end
            OP_BLEZ: begin
                d.is_br = 1'b1;
                d.taken = lez_sig;
            end
            OP_BGTZ: begin
                d.is_br = 1'b1;
                d.taken = gtz_sig;
            end
            OP_REGIMM: begin
                // Only bltz/bgez are branches; other REGIMM forms are left to the main decoder.
                if (rt == RT_BLTZ) begin
                    d.is_br = 1'b1;
                    d.taken = ltz_sig;
                end else if (rt == RT_BGEZ) begin
                    d.is_br = 1'b1;
                    d.taken = gez_sig;
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic src_match(
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        return (rd != 5'd0) && ((rd == rs) || (use_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/branch_hazard.sv
// Sizes the operand stall a branch in ID needs before its comparator flags are valid,
// from the EX and MEM destination fields.
module branch_hazard
    import mips_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rt,
    input  logic       ex_wr_en,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       mem_wr_en,
    input  logic       mem_is_load,
    input  logic [4:0] mem_rd,
    output logic [1:0] need
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_wr_en  && src_match(ex_rd,  rs, rt, use_rt);
    assign mem_hit = mem_wr_en && src_match(mem_rd, rs, rt, use_rt);

    // A MEM ALU result is already forwardable into ID, so only a MEM load costs a cycle.
    always_comb begin
        need = NEED_NONE;
        if (ex_hit && ex_is_load) begin
            need = NEED_TWO;
        end else if (ex_hit || (mem_hit && mem_is_load)) begin
            need = NEED_ONE;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: operand-hazard stall, target computation, registered
// PC redirect / IF-ID flush, and wrapping branch/taken counters.
//
// state | meaning
// IDLE  | no branch held; a new branch resolves now or starts a stall
// WAIT  | branch held in ID; cnt more stall cycles before it resolves
module branch_resolve
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [15:0] id_imm,
    input  logic [31:0] id_pc4,
    input  logic        res_eq,
    input  logic        gtz_sig,
    input  logic        lez_sig,
    input  logic        gez_sig,
    input  logic        ltz_sig,
    input  logic        ex_wr_en,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        mem_wr_en,
    input  logic        mem_is_load,
    input  logic [4:0]  mem_rd,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        flush_ifid,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
);

    br_state_t   state;
    logic [1:0]  cnt;
    br_dec_t     dec;
    logic [1:0]  need;
    logic        accept;
    logic        resolve;
    logic        stall_int;
    logic [31:0] imm_ext;
    logic [31:0] target;

    assign dec = decode_branch(id_opcode, id_rt, res_eq, gtz_sig, lez_sig, gez_sig, ltz_sig);

    branch_hazard u_hazard (
        .rs          (id_rs),
        .rt          (id_rt),
        .use_rt      (dec.use_rt),
        .ex_wr_en    (ex_wr_en),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .mem_wr_en   (mem_wr_en),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .need        (need)
    );

    // While a redirect is issued, ID holds the delay slot: never treat it as a new branch.
    assign accept    = (state == IDLE) && id_valid && dec.is_br && !pc_redirect;
    assign resolve   = (accept && (need == NEED_NONE)) || ((state == WAIT) && (cnt == 2'd0));
    assign stall_int = (accept && (need != NEED_NONE)) || ((state == WAIT) && (cnt != 2'd0));
    assign stall     = rst_n && stall_int;

    assign imm_ext = {{14{id_imm[15]}}, id_imm, 2'b00};
    assign target  = id_pc4 + imm_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (need != NEED_NONE)) begin
                        cnt   <= need - 2'd1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_redirect <= 1'b0;
            pc_target   <= 32'd0;
            br_cnt      <= 32'd0;
            taken_cnt   <= 32'd0;
        end else begin
            pc_redirect <= resolve && dec.taken;
            if (resolve) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (resolve && dec.taken) begin
                pc_target <= target;
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end

    assign flush_ifid = pc_redirect;

endmodule
